sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the width of the incoming adder sum.
REQ-002 The block SHALL have parameter ACC_W, default 16, the width of the accumulator and result.
REQ-003 The block SHALL have parameter FRAME_LEN, default 4, the number of sums per frame (legal range 1..1024).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port sum_in  input  DATA_W  unsigned sum from the upstream combinational adder.
REQ-008 Port in_valid  input  1  sum_in is valid this cycle.
REQ-009 Port in_ready  output  1  block accepts sum_in this cycle.
REQ-010 Port clear  input  1  synchronous frame abort.
REQ-011 Port acc_out  output  ACC_W  completed frame total.
REQ-012 Port overflow  output  1  frame total exceeded ACC_W bits; valid with out_valid.
REQ-013 Port out_valid  output  1  acc_out/overflow hold a completed frame.
REQ-014 Port out_ready  input  1  downstream consumes the result.

Function
REQ-015 States SHALL be IDLE (no samples taken), ACCUM (1..FRAME_LEN-1 samples taken), HOLD (result presented).
REQ-016 A sample SHALL be accepted only on a cycle where in_valid and in_ready are both high.
REQ-017 in_ready SHALL be high in IDLE and ACCUM and low in HOLD.
REQ-018 Each accepted sum_in SHALL be zero-extended to ACC_W and added into the accumulator, with the result taken modulo 2^ACC_W.
REQ-019 A carry out of bit ACC_W-1 on any add within a frame SHALL set a sticky overflow bit for that frame.
REQ-020 IDLE -> ACCUM on an accepted sample when FRAME_LEN > 1; IDLE -> HOLD directly when FRAME_LEN = 1.
REQ-021 ACCUM -> HOLD on the accepted sample that brings the count to FRAME_LEN.
REQ-022 In the cycle after the final sample is accepted, out_valid SHALL be 1, and acc_out and overflow SHALL carry the full-frame result (one-cycle latency).
REQ-023 In HOLD, acc_out, overflow and out_valid SHALL remain stable until out_ready is high.
REQ-024 HOLD -> IDLE on out_valid and out_ready; the next cycle SHALL have out_valid 0, in_ready 1, and the accumulator, count and overflow cleared.
REQ-025 No sample SHALL be accepted in the same cycle as the output handshake.
REQ-026 If clear is high in any state, the next state SHALL be IDLE, with the accumulator, count, overflow and out_valid cleared and any partial or unconsumed result discarded; clear SHALL take priority over in_valid and out_ready.
REQ-027 The sample counter SHALL be $clog2(FRAME_LEN+1) bits wide and SHALL never exceed FRAME_LEN.

Reset
REQ-028 When rst_n is low, the state SHALL be IDLE and acc_out, overflow, out_valid and the count SHALL be 0, independent of clk.
REQ-029 in_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first clk edge after deassertion.
REQ-030 A reset asserted mid-frame or in HOLD SHALL discard all frame data.

Structure
REQ-031 Package sum_acc_pkg SHALL hold the state enumeration and the default DATA_W, ACC_W and FRAME_LEN constants.
REQ-032 The block SHALL be a single module with no sub-modules; the counter and accumulator are inline registers.
REQ-033 acc_out, overflow, out_valid and in_ready SHALL be driven from registers or from the state register only, with no combinational path from inputs to outputs.

Verification
REQ-034 With FRAME_LEN=4, in_valid held high with sums 10, 120, 64, 80 and out_ready=1 -> out_valid high for one cycle, acc_out=274, overflow=0, one cycle after the 4th accept.
REQ-035 Same frame with out_ready low for 3 cycles -> out_valid, acc_out=274 and in_ready=0 all held stable, no sample accepted; out_ready=1 -> IDLE next cycle.
REQ-036 With FRAME_LEN=300, 300 sums of 255 -> acc_out=10964 (76500 mod 65536) and overflow=1; the next frame of 300 sums of 1 -> acc_out=300, overflow=0.
REQ-037 With FRAME_LEN=4, accept 2 sums (50, 50), pulse clear, then 4 sums of 1 -> acc_out=4.
REQ-038 Assert rst_n low asynchronously during HOLD -> out_valid and acc_out are 0 before the next clk edge; after release, in_valid stalled low for several cycles -> no count change.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared state encoding and default sizing for the frame sum accumulator.
package sum_acc_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ACC_W     = 16;
   localparam int DEF_FRAME_LEN = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Sums FRAME_LEN accepted samples per frame, flags carry out, presents the total.
// Latency: result valid one cycle after the final sample is accepted.
// Backpressure: in_ready low while a result waits; result held until out_ready.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sum_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               rdy_q, vld_q;
   logic               take;
   logic [ACC_W:0]     add_res;

   always_comb begin
      add_res = {1'b0, acc_q} + (ACC_W + 1)'(sum_in);
      take    = in_valid && rdy_q;
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (take) begin
                  acc_d   = add_res[ACC_W-1:0];
                  ovf_d   = ovf_q | add_res[ACC_W];
                  cnt_d   = cnt_q + CNT_W'(1);
                  // The sample that completes the frame goes straight to HOLD.
                  state_d = (cnt_q == LAST_CNT) ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // Handshake flags are registered from the next state so no input reaches an output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdy_q   <= (state_d != HOLD);
         vld_q   <= (state_d == HOLD);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign acc_out   = acc_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Random and directed frames against an arithmetic frame-total model, three frame lengths.
module tb_sum_accumulator;

   localparam int NI = 3;
   localparam int FL [NI] = '{4, 300, 1};

   logic        clk;
   logic        rst_n;
   logic [7:0]  sum_in    [NI];
   logic        in_valid  [NI];
   logic        in_ready  [NI];
   logic        clear     [NI];
   logic [15:0] acc_out   [NI];
   logic        overflow  [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] fq[$];
   longint     exp_acc;
   logic       exp_ovf;

   sum_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(4)) u_f4 (
      .clk(clk), .rst_n(rst_n), .sum_in(sum_in[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .clear(clear[0]), .acc_out(acc_out[0]),
      .overflow(overflow[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   sum_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(300)) u_f300 (
      .clk(clk), .rst_n(rst_n), .sum_in(sum_in[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .clear(clear[1]), .acc_out(acc_out[1]),
      .overflow(overflow[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   sum_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(1)) u_f1 (
      .clk(clk), .rst_n(rst_n), .sum_in(sum_in[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .clear(clear[2]), .acc_out(acc_out[2]),
      .overflow(overflow[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives the values in fq into instance k with random idle gaps; model total is plain arithmetic.
   task automatic send_frame(input int k, input int gap_pct);
      int     idx = 0;
      int     budget = 0;
      longint tot = 0;
      logic   took;
      while (idx < fq.size() && budget < 5000) begin
         if ($urandom_range(99) < gap_pct) begin
            in_valid[k] = 1'b0;
            sum_in[k]   = 8'($urandom);
         end else begin
            in_valid[k] = 1'b1;
            sum_in[k]   = fq[idx];
         end
         took = in_valid[k] && in_ready[k];
         @(posedge clk); #1;
         if (took) begin
            tot += longint'(fq[idx]);
            idx++;
         end
         budget++;
         if (idx < fq.size()) chk("no_early_valid", 32'(out_valid[k]), 32'd0);
      end
      in_valid[k] = 1'b0;
      chk("frame_all_accepted", 32'(idx), 32'(fq.size()));
      exp_acc = tot % 65536;
      exp_ovf = (tot > 65535);
   endtask

   // Called right after the final accept: checks latency, stability under stall, and release.
   task automatic check_result(input int k, input int stall);
      chk("result_valid", 32'(out_valid[k]), 32'd1);
      chk("result_acc", 32'(acc_out[k]), 32'(exp_acc));
      chk("result_ovf", 32'(overflow[k]), 32'(exp_ovf));
      for (int c = 0; c < stall; c++) begin
         out_ready[k] = 1'b0;
         in_valid[k]  = 1'b1;
         sum_in[k]    = 8'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid[k]), 32'd1);
         chk("hold_acc", 32'(acc_out[k]), 32'(exp_acc));
         chk("hold_ovf", 32'(overflow[k]), 32'(exp_ovf));
         chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
      end
      out_ready[k] = 1'b1;
      in_valid[k]  = 1'b1;
      sum_in[k]    = 8'($urandom);
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b0;
      chk("release_valid", 32'(out_valid[k]), 32'd0);
      chk("release_in_ready", 32'(in_ready[k]), 32'd1);
      chk("release_acc_clr", 32'(acc_out[k]), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         sum_in[k] = '0; in_valid[k] = 1'b0; clear[k] = 1'b0; out_ready[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid[0]), 32'd0);
      chk("rst_acc", 32'(acc_out[0]), 32'd0);
      chk("rst_ovf", 32'(overflow[0]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready_pre_edge", 32'(in_ready[0]), 32'd0);
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(in_ready[0]), 32'd1);

      // Directed frame 10,120,64,80 without and with a three-cycle stall.
      fq = '{8'd10, 8'd120, 8'd64, 8'd80};
      send_frame(0, 0);
      chk("directed_total", 32'(exp_acc), 32'd274);
      check_result(0, 0);
      send_frame(0, 0);
      check_result(0, 3);

      for (int f = 0; f < 8; f++) begin
         fq.delete();
         for (int i = 0; i < FL[0]; i++) fq.push_back(8'($urandom));
         send_frame(0, 30);
         check_result(0, $urandom_range(0, 3));
      end

      // Abort mid-frame with a competing valid sample, then a fresh frame of ones.
      fq = '{8'd50, 8'd50};
      send_frame(0, 0);
      clear[0] = 1'b1; in_valid[0] = 1'b1; sum_in[0] = 8'd99;
      @(posedge clk); #1;
      clear[0] = 1'b0; in_valid[0] = 1'b0;
      chk("clear_valid", 32'(out_valid[0]), 32'd0);
      chk("clear_acc", 32'(acc_out[0]), 32'd0);
      fq = '{8'd1, 8'd1, 8'd1, 8'd1};
      send_frame(0, 0);
      check_result(0, 1);

      // Abort in HOLD discards the unconsumed result.
      fq = '{8'd200, 8'd200, 8'd200, 8'd200};
      send_frame(0, 0);
      chk("pre_clear_hold", 32'(out_valid[0]), 32'd1);
      clear[0] = 1'b1; out_ready[0] = 1'b1;
      @(posedge clk); #1;
      clear[0] = 1'b0; out_ready[0] = 1'b0;
      chk("clear_hold_valid", 32'(out_valid[0]), 32'd0);
      chk("clear_hold_ready", 32'(in_ready[0]), 32'd1);
      chk("clear_hold_ovf", 32'(overflow[0]), 32'd0);

      // Asynchronous reset while holding a result.
      fq = '{8'd255, 8'd255, 8'd255, 8'd255};
      send_frame(0, 0);
      chk("pre_rst_hold", 32'(out_valid[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("async_rst_acc", 32'(acc_out[0]), 32'd0);
      chk("async_rst_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid[0] = 1'b0;
         sum_in[0]   = 8'($urandom);
         @(posedge clk); #1;
         chk("stall_no_valid", 32'(out_valid[0]), 32'd0);
         chk("stall_ready", 32'(in_ready[0]), 32'd1);
      end
      fq = '{8'd3, 8'd5, 8'd7, 8'd11};
      send_frame(0, 0);
      check_result(0, 0);

      // Long frames: wrap with overflow, then a clean frame.
      fq.delete();
      for (int i = 0; i < 300; i++) fq.push_back(8'd255);
      send_frame(1, 0);
      chk("f300_model_total", 32'(exp_acc), 32'd10964);
      check_result(1, 2);
      fq.delete();
      for (int i = 0; i < 300; i++) fq.push_back(8'd1);
      send_frame(1, 10);
      check_result(1, 0);

      // Single-sample frames.
      for (int f = 0; f < 6; f++) begin
         fq = '{8'($urandom)};
         send_frame(2, 30);
         check_result(2, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
